// File: rtl/riscv_mult.sv
// Issue/retire stage in front of riscv_mult: a 2-entry in-order op queue, a
// small IDLE/EXEC/KILL tracker for the multicycle MULH sequence, and a
// registered writeback slot with valid/ready handshake.
module riscv_mult_issue #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             id_valid_i,
  output logic             id_ready_o,
  input  logic [2:0]       id_operator_i,
  input  logic             id_short_subword_i,
  input  logic [1:0]       id_short_signed_i,
  input  logic [1:0]       id_dot_signed_i,
  input  logic [4:0]       id_imm_i,
  input  logic [31:0]      id_op_a_i,
  input  logic [31:0]      id_op_b_i,
  input  logic [31:0]      id_op_c_i,
  input  logic [TAG_W-1:0] id_tag_i,
  output logic             mult_enable_o,
  output logic [2:0]       mult_operator_o,
  output logic             mult_short_subword_o,
  output logic [1:0]       mult_short_signed_o,
  output logic [4:0]       mult_imm_o,
  output logic [31:0]      mult_op_a_o,
  output logic [31:0]      mult_op_b_o,
  output logic [31:0]      mult_op_c_o,
  output logic [1:0]       mult_dot_signed_o,
  output logic [31:0]      mult_dot_op_a_o,
  output logic [31:0]      mult_dot_op_b_o,
  output logic [31:0]      mult_dot_op_c_o,
  input  logic [31:0]      mult_result_i,
  input  logic             mult_ready_i,
  output logic             mult_ex_ready_o,
  output logic             wb_valid_o,
  input  logic             wb_ready_i,
  output logic [31:0]      wb_result_o,
  output logic [TAG_W-1:0] wb_tag_o
);

  localparam logic [2:0] MUL_H = 3'b110;

  typedef struct packed {
    logic [2:0]       op;
    logic             subword;
    logic [1:0]       ssign;
    logic [1:0]       dsign;
    logic [4:0]       imm;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [31:0]      c;
    logic [TAG_W-1:0] tag;
  } entry_t;

  typedef enum logic [1:0] {IDLE, EXEC, KILL} state_t;

  entry_t     q [2];
  entry_t     head;
  logic       rd_ptr, wr_ptr;
  logic [1:0] count;
  state_t     state;

  logic head_valid, head_mulh, wb_free, push, ret, kill_done;

  assign head       = q[rd_ptr];
  assign head_valid = (count != 2'd0);
  assign head_mulh  = (head.op == MUL_H);
  assign wb_free    = !wb_valid_o || wb_ready_i;

  assign id_ready_o    = (count != 2'd2) && (state != KILL);
  assign push          = id_valid_i && id_ready_o && !flush_i;
  assign mult_enable_o = head_valid && (state != KILL);

  // Normal retire needs a free wb slot; flush wins over a same-cycle retire.
  assign ret       = head_valid && mult_ready_i && wb_free && (state != KILL) && !flush_i;
  // A killed MULH still has to be walked out of the multiplier's FINISH state.
  assign kill_done = (state == KILL) && head_valid && mult_ready_i;
  assign mult_ex_ready_o = ret || kill_done;

  assign mult_operator_o      = head.op;
  assign mult_short_subword_o = head.subword;
  assign mult_short_signed_o  = head.ssign;
  assign mult_imm_o           = head.imm;
  assign mult_op_a_o          = head.a;
  assign mult_op_b_o          = head.b;
  assign mult_op_c_o          = head.c;
  assign mult_dot_signed_o    = head.dsign;
  assign mult_dot_op_a_o      = head.a;
  assign mult_dot_op_b_o      = head.b;
  assign mult_dot_op_c_o      = head.c;

  // Queue storage: datapath only, written at the tail on an accepted push.
  always_ff @(posedge clk) begin
    if (push)
      q[wr_ptr] <= '{op: id_operator_i, subword: id_short_subword_i, ssign: id_short_signed_i,
                     dsign: id_dot_signed_i, imm: id_imm_i, a: id_op_a_i, b: id_op_b_i,
                     c: id_op_c_i, tag: id_tag_i};
  end

  // Queue pointers, MULH tracking state and writeback register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      count       <= 2'd0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      wb_valid_o  <= 1'b0;
      wb_result_o <= '0;
      wb_tag_o    <= '0;
    end else if (flush_i) begin
      wb_valid_o <= 1'b0;
      if (kill_done) begin
        // killed MULH leaves this cycle; nothing else survives
        rd_ptr <= rd_ptr + 1'b1;
        wr_ptr <= rd_ptr + 1'b1;
        count  <= 2'd0;
        state  <= IDLE;
      end else if (head_valid && head_mulh) begin
        // MULH head has already started in the mult: keep it to drain it
        wr_ptr <= rd_ptr + 1'b1;
        count  <= 2'd1;
        state  <= KILL;
      end else begin
        wr_ptr <= rd_ptr;
        count  <= 2'd0;
        state  <= IDLE;
      end
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (mult_ex_ready_o) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {1'b0, push} - {1'b0, mult_ex_ready_o};

      case (state)
        IDLE:    if (head_valid && head_mulh && !ret) state <= EXEC;
        EXEC:    if (ret) state <= IDLE;
        KILL:    if (kill_done) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (ret) begin
        wb_valid_o  <= 1'b1;
        wb_result_o <= mult_result_i;
        wb_tag_o    <= head.tag;
      end else if (wb_ready_i) begin
        wb_valid_o <= 1'b0;
      end
    end
  end

endmodule
